sram_mem_responder: RTL and testbench
=====================================

Name: sram_mem_responder

Overview:
Memory-side responder for the MEM stage's data-memory requests (mem_read/mem_write, ALU-result address, Val_Rm store data). Serves each 32-bit word request as two 16-bit accesses to an external SRAM. Holds ready low while busy; ready low drives the pipeline freeze, so the request stays stable until ready returns high.

Parameters:
BASE_ADDR, 1024, byte address mapped to SRAM location 0
SRAM_ADDR_W, 18, SRAM address width, in 16-bit half-words
WAIT_CYCLES, 3, cycles per 16-bit SRAM access phase (minimum 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
rd_en  in  1  read request (MEM-stage mem_read)
wr_en  in  1  write request (MEM-stage mem_write)
address  in  32  byte address (ALU result)
write_data  in  32  store data (Val_Rm)
read_data  out  32  load data; held until the next read completes
ready  out  1  1 = idle or completing; 0 = busy, pipeline freezes
sram_addr  out  SRAM_ADDR_W  SRAM half-word address
sram_dq_out  out  16  SRAM write data
sram_dq_in  in  16  SRAM read data
sram_dq_oe  out  1  1 = controller drives the DQ bus
sram_we_n  out  1  SRAM write enable, active-low
sram_oe_n  out  1  SRAM output enable, active-low

Behaviour:
- Clock and reset: one clock, clk. Reset on rst is asynchronous and active-low.
- Reset values:
  - read_data = 0, sram_addr = 0, sram_dq_out = 0
  - sram_dq_oe = 0, sram_we_n = 1, sram_oe_n = 1
  - state = IDLE, counter = 0
- Address map:
  - offset = address - BASE_ADDR, computed modulo 2^32.
  - Low half: sram_addr = {offset[SRAM_ADDR_W:2], 1'b0}.
  - High half: sram_addr = {offset[SRAM_ADDR_W:2], 1'b1}.
  - offset[1:0] is ignored. Offset bits above SRAM_ADDR_W are ignored, so addresses wrap.
- Request and priority: req = rd_en | wr_en. When both are high, the write wins and no read is performed.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: ready = !req. If req, latch op, word address and write_data, then go to LOW with counter = 0.
  - LOW: drive the low half for WAIT_CYCLES cycles. On counter == WAIT_CYCLES-1, go to HIGH and clear the counter.
  - HIGH: same as LOW for the high half. On completion, go to DONE.
  - DONE: ready = 1 for exactly one cycle, then go to IDLE.
- Latency: a request first presented at cycle 0 gets ready = 1 at cycle 2*WAIT_CYCLES + 1 (cycle 7 at the default). The pipeline advances on that edge.
- Read phases:
  - sram_oe_n = 0, sram_dq_oe = 0.
  - sram_dq_in is sampled on the last cycle of each phase: LOW gives read_data[15:0], HIGH gives read_data[31:16].
  - read_data updates atomically at DONE. It must not show a partial word.
- Write phases:
  - sram_we_n = 0, sram_dq_oe = 1.
  - sram_dq_out = write_data[15:0] in LOW and write_data[31:16] in HIGH.
  - Address and data are stable for the whole phase. At DONE, sram_we_n = 1 and sram_dq_oe = 0.
- Outside LOW/HIGH: sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0.
- Request dropped mid-operation: the access still completes using the latched values. The DONE cycle still occurs.
- Back-to-back requests: a request held high in the cycle after DONE is treated as a new request and starts from IDLE.
- Reset mid-operation: all outputs return to their reset values immediately. A partial SRAM write is acceptable. The next request runs normally.

Optional Feature:
SRAM_READ_HIT_EN
- With the macro defined:
  - A one-entry tag (word address plus valid bit) records the last completed read.
  - A read in IDLE that matches the tag, with valid set, goes directly to DONE with no SRAM access. ready goes high at cycle 1.
  - Any write clears valid. Reset clears valid.
- Without the macro: no tag exists, and every read takes the full latency.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - the state enum (IDLE, LOW, HIGH, DONE)
  - the default BASE_ADDR and WAIT_CYCLES constants
  - the 16-bit half-word width constant
- Natural sub-module: sram_phase_timer.
  - Parameterised by WAIT_CYCLES; inputs start and clear.
  - Outputs a last-cycle pulse.
  - Shared by the LOW and HIGH phases.

Test Plan:
- Reset, with no request applied: ready = 1, sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0, read_data = 0.
- Write 0xDEADBEEF to address 1028:
  - SRAM address 2 receives 0xBEEF during cycles 1-3.
  - SRAM address 3 receives 0xDEAD during cycles 4-6.
  - ready = 0 in cycles 0-6 and ready = 1 at cycle 7.
- Read address 1028 against the SRAM model:
  - read_data = 0xDEADBEEF at cycle 7.
  - Neither half is visible earlier; read_data holds its previous value until cycle 7.
- rd_en = wr_en = 1 to address 1032 with write_data 0x12345678: a write is performed, sram_oe_n never goes low, and a later read returns 0x12345678.
- Reset in cycle 3 of a read:
  - All outputs take their reset values within that cycle.
  - A new read of 1028 returns 0xDEADBEEF at cycle 7.
- With SRAM_READ_HIT_EN:
  - A second read of 1028 returns ready at cycle 1.
  - After a write to 1028, the next read takes the full 7 cycles.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the MEM-stage SRAM responder and its phase timer.
//   state_e         : responder FSM states (IDLE, LOW, HIGH, DONE)
//   DEF_BASE_ADDR   : default byte address mapped to SRAM half-word 0
//   DEF_WAIT_CYCLES : default cycles per 16-bit SRAM access phase
//   HALF_W          : SRAM data bus width (one half of a 32-bit word)
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int          DEF_WAIT_CYCLES = 3;
    localparam int          HALF_W          = 16;

endpackage

// File: rtl/sram_phase_timer.sv
// ---------------------------------------------------------------------------
// sram_phase_timer
// Counts the cycles of one SRAM access phase and flags the final cycle.
// The same instance times both the LOW and the HIGH phase: the counter wraps
// to zero on its last cycle, so the next phase starts fresh.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start_i : phase is active this cycle (count it)
//   clear_i : force the counter back to zero
//   last_o  : high during the final cycle of an active phase
// ---------------------------------------------------------------------------
module sram_phase_timer #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic clear_i,
    output logic last_o
);

    // At least one bit so WAIT_CYCLES == 1 still elaborates.
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    assign last_o = start_i && (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (clear_i || last_o) begin
            count_d = '0;
        end else if (start_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sram_mem_responder.sv
// ---------------------------------------------------------------------------
// sram_mem_responder
// Serves MEM-stage 32-bit data-memory requests as two 16-bit accesses to an
// external SRAM (low half first, then high half). ready is low while busy so
// the pipeline freezes and the request stays stable.
//
// Optional build macro: SRAM_READ_HIT_EN
//   When defined, a one-entry tag remembers the word address of the last
//   completed read; a repeated read of that word skips the SRAM and completes
//   in one cycle. Any write (and reset) invalidates the tag.
//
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   rd_en, wr_en : read / write request (write wins when both are set)
//   address      : byte address (ALU result)
//   write_data   : store data
//   read_data    : load data, held until the next read completes
//   ready        : 1 = idle or completing, 0 = busy (pipeline freeze)
//   sram_addr    : SRAM half-word address
//   sram_dq_out  : SRAM write data
//   sram_dq_in   : SRAM read data
//   sram_dq_oe   : controller drives the DQ bus
//   sram_we_n    : SRAM write enable, active-low
//   sram_oe_n    : SRAM output enable, active-low
// ---------------------------------------------------------------------------
module sram_mem_responder
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          SRAM_ADDR_W = 18,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [HALF_W-1:0]      sram_dq_out,
    input  logic [HALF_W-1:0]      sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    // Word address = half-word address without its lowest bit.
    localparam int WORD_W = SRAM_ADDR_W - 1;

    state_e                   state_q, state_d;
    logic                     is_write_q, is_write_d;
    logic [WORD_W-1:0]        word_q, word_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [HALF_W-1:0]        low_buf_q, low_buf_d;
    logic [31:0]              read_data_q, read_data_d;
    logic [SRAM_ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [HALF_W-1:0]        dq_out_q, dq_out_d;
    logic                     dq_oe_q, dq_oe_d;
    logic                     we_n_q, we_n_d;
    logic                     oe_n_q, oe_n_d;

    logic                     req;
    logic [31:0]              offset;
    logic [WORD_W-1:0]        req_word;
    logic                     phase_active;
    logic                     phase_last;
    logic                     read_hit;

    assign req      = rd_en | wr_en;
    // Modulo-2^32 subtraction; bits above the SRAM range are dropped so
    // addresses wrap, and the byte lane bits are ignored.
    assign offset   = address - BASE_ADDR;
    assign req_word = offset[SRAM_ADDR_W:2];

    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

    assign phase_active = (state_q == LOW) || (state_q == HIGH);

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase_timer (
        .clk     (clk),
        .rst_n   (rst),
        .start_i (phase_active),
        .clear_i (!phase_active),
        .last_o  (phase_last)
    );

`ifdef SRAM_READ_HIT_EN
    logic [WORD_W-1:0] tag_q, tag_d;
    logic              tag_valid_q, tag_valid_d;

    assign read_hit = rd_en && !wr_en && tag_valid_q && (tag_q == req_word);

    always_comb begin
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        if (state_q == IDLE && wr_en) begin
            tag_valid_d = 1'b0;
        end else if (state_q == HIGH && phase_last && !is_write_q) begin
            tag_d       = word_q;
            tag_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
        end
    end
`else
    assign read_hit = 1'b0;
`endif

    // Next-state and request latching.
    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        low_buf_d   = low_buf_q;
        read_data_d = read_data_q;
        ready       = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready = !req;
                if (req) begin
                    is_write_d = wr_en;
                    word_d     = req_word;
                    wdata_d    = write_data;
                    state_d    = read_hit ? DONE : LOW;
                end
            end
            LOW: begin
                if (phase_last) begin
                    low_buf_d = sram_dq_in;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    // Both halves land together so read_data never shows a
                    // partially updated word.
                    if (!is_write_q) begin
                        read_data_d = {sram_dq_in, low_buf_q};
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // SRAM pins are registered from the next state, so address, data and
    // strobes change only on phase boundaries and stay stable within a phase.
    always_comb begin
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        if (state_d == LOW || state_d == HIGH) begin
            sram_addr_d = {word_d, (state_d == HIGH)};
            if (is_write_d) begin
                we_n_d   = 1'b0;
                dq_oe_d  = 1'b1;
                dq_out_d = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
            end else begin
                oe_n_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            is_write_q  <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            low_buf_q   <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            low_buf_q   <= low_buf_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
        end
    end

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_sram_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_mem_responder
// Drives directed and randomized word requests into sram_mem_responder,
// attached to a behavioural 16-bit SRAM. Expected load data comes from a
// word-level reference memory; expected bus activity and latency come from
// the responder's documented timing.
// ---------------------------------------------------------------------------
module tb_sram_mem_responder;

    localparam int          W    = 3;
    localparam int          AW   = 18;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int          MAX_WAIT = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en, wr_en;
    logic [31:0]   address, write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out, sram_dq_in;
    logic          sram_dq_oe, sram_we_n, sram_oe_n;

    sram_mem_responder #(
        .BASE_ADDR   (BASE),
        .SRAM_ADDR_W (AW),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM: writes land on the clock edge while
    // we_n is low, reads are combinational.
    logic [15:0] sram_mem [0:(1<<AW)-1] = '{default: 16'h0};
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
    end

    // Reference model state.
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_read_val = 32'h0;
    bit          hit_valid = 1'b0;
    int unsigned hit_word  = 0;

    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (off >> 2) % (32'd1 << (AW - 1));
    endfunction

    function automatic logic [31:0] ref_read(input int unsigned w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return 32'h0;
    endfunction

    // One request from presentation (cycle 0) to ready; checks bus activity
    // every cycle, the latency, and the data at completion.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input bit drop_mid);
        int unsigned w;
        bit          is_wr, hit, done;
        int          cyc, exp_lat;
        logic [31:0] exp_addr, exp_rd;

        w     = word_of(addr);
        is_wr = wr;
        hit   = 1'b0;
`ifdef SRAM_READ_HIT_EN
        hit = !is_wr && hit_valid && (hit_word == w);
`endif
        exp_lat = hit ? 1 : 2 * W + 1;

        @(negedge clk);
        rd_en = rd; wr_en = wr; address = addr; write_data = data;
        #1 chk("ready_cycle0", {31'h0, ready}, 32'h0);

        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < MAX_WAIT) begin
            @(negedge clk);
            cyc++;
            if (ready) begin
                done = 1'b1;
            end else begin
                chk("rdata_hold", read_data, last_read_val);
                if (!hit && cyc <= 2 * W) begin
                    exp_addr = 2 * w + ((cyc > W) ? 1 : 0);
                    chk("sram_addr", {{(32-AW){1'b0}}, sram_addr}, exp_addr);
                    chk("we_n", {31'h0, sram_we_n}, is_wr ? 32'h0 : 32'h1);
                    chk("oe_n", {31'h0, sram_oe_n}, is_wr ? 32'h1 : 32'h0);
                    chk("dq_oe", {31'h0, sram_dq_oe}, is_wr ? 32'h1 : 32'h0);
                    if (is_wr)
                        chk("dq_out", {16'h0, sram_dq_out},
                            {16'h0, (cyc > W) ? data[31:16] : data[15:0]});
                end
                if (drop_mid && cyc == 2) begin
                    rd_en = 1'b0; wr_en = 1'b0;
                    address = $urandom; write_data = $urandom;
                end
            end
        end
        chk("latency", cyc, exp_lat);
        chk("done_we_n", {31'h0, sram_we_n}, 32'h1);
        chk("done_oe_n", {31'h0, sram_oe_n}, 32'h1);
        chk("done_dq_oe", {31'h0, sram_dq_oe}, 32'h0);

        if (is_wr) begin
            ref_mem[w] = data;
            hit_valid  = 1'b0;
            chk("wr_rdata_kept", read_data, last_read_val);
        end else begin
            exp_rd = ref_read(w);
            chk("read_data", read_data, exp_rd);
            last_read_val = exp_rd;
            hit_valid     = 1'b1;
            hit_word      = w;
        end
        $display("txn %0d: %s addr=%h data=%h word=%0d latency=%0d",
                 n_txn, is_wr ? "WR" : "RD", addr, is_wr ? data : read_data, w, cyc);
        n_txn++;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        bit          r, wbit, drop;
        logic [31:0] a, d;

        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_we_n", {31'h0, sram_we_n}, 32'h1);
        chk("rst_oe_n", {31'h0, sram_oe_n}, 32'h1);
        chk("rst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
        chk("rst_rdata", read_data, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'h0, ready}, 32'h1);

        // Directed cases.
        run_txn(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
        chk("sram_half2", {16'h0, sram_mem[2]}, 32'h0000BEEF);
        chk("sram_half3", {16'h0, sram_mem[3]}, 32'h0000DEAD);
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        run_txn(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0);
        run_txn(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        run_txn(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);

        // Reset during cycle 3 of a read.
        @(negedge clk);
        rd_en = 1'b1; address = 32'd1032;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_rdata", read_data, 32'h0);
        chk("mid_rst_addr", {{(32-AW){1'b0}}, sram_addr}, 32'h0);
        chk("mid_rst_dq_out", {16'h0, sram_dq_out}, 32'h0);
        chk("mid_rst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
        chk("mid_rst_we_n", {31'h0, sram_we_n}, 32'h1);
        chk("mid_rst_oe_n", {31'h0, sram_oe_n}, 32'h1);
        rd_en = 1'b0;
        #1 chk("mid_rst_ready", {31'h0, ready}, 32'h1);
        last_read_val = 32'h0;
        hit_valid     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);

        // Byte-lane bits ignored, high offset bits wrap, request dropped.
        run_txn(1'b1, 1'b0, 32'd1031, 32'h0, 1'b1);
        run_txn(1'b1, 1'b0, 32'd1028 + (32'd1 << 19), 32'h0, 1'b0);
        run_txn(1'b0, 1'b1, 32'd1036, 32'hA5A5_0F0F, 1'b1);
        run_txn(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0)
                a = $urandom;
            else
                a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3)
                    + ($urandom_range(0, 3) == 0 ? (32'd1 << 20) : 32'd0);
            d    = $urandom;
            r    = $urandom_range(0, 1);
            wbit = $urandom_range(0, 2) == 0;
            if (!r && !wbit) r = 1'b1;
            drop = $urandom_range(0, 3) == 0;
            run_txn(r, wbit, a, d, drop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
